// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit: the md_op encoding and
// width (also used by the controller when decoding MD-class instructions)
// and the FSM state type.
// ---------------------------------------------------------------------------
package mdu_pkg;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

endpackage : mdu_pkg

// File: rtl/mdu_calc.sv
// ---------------------------------------------------------------------------
// mdu_calc
// Purely combinational arithmetic core of the MDU. Produces the full 64-bit
// {hi,lo} result for MULT/MULTU/DIV/DIVU in one evaluation; the owning block
// registers it and models latency with a counter.
//   op          : md_op encoding (only 0..3 produce a meaningful result)
//   a, b        : rs / rt operands
//   result      : {hi, lo}; mult = {upper, lower}, div = {remainder, quotient}
//   div_by_zero : DIV/DIVU with b == 0 (result is then don't-care)
// ---------------------------------------------------------------------------
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic [63:0]        result,
    output logic               div_by_zero
);

    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] product_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [31:0] dividend_s;
    logic [31:0] divisor_s;
    logic [31:0] quot_raw_s;
    logic [31:0] rem_raw_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Shared 64x64 multiplier: sign- or zero-extend operands, keep low 64 bits.
    always_comb begin
        mul_a_s = {32'd0, a};
        mul_b_s = {32'd0, b};
        if (op == MD_MULT) begin
            mul_a_s = {{32{a[31]}}, a};
            mul_b_s = {{32{b[31]}}, b};
        end else begin
            mul_a_s = {32'd0, a};
            mul_b_s = {32'd0, b};
        end
        product_s = mul_a_s * mul_b_s;
    end

    // Shared unsigned divider; signed DIV runs on magnitudes and fixes signs after.
    // A zero divisor is replaced by 1 so the datapath never sees X; the flag
    // tells the owner to discard the result.
    always_comb begin
        abs_a_s    = a[31] ? (32'd0 - a) : a;
        abs_b_s    = b[31] ? (32'd0 - b) : b;
        dividend_s = a;
        divisor_s  = b;
        if (op == MD_DIV) begin
            dividend_s = abs_a_s;
            divisor_s  = abs_b_s;
        end else begin
            dividend_s = a;
            divisor_s  = b;
        end
        if (divisor_s == 32'd0) begin
            divisor_s = 32'd1;
        end else begin
            divisor_s = divisor_s;
        end
        quot_raw_s = dividend_s / divisor_s;
        rem_raw_s  = dividend_s % divisor_s;
        // Quotient negative when operand signs differ; remainder follows dividend.
        // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negates to itself.
        if (op == MD_DIV) begin
            quot_s = (a[31] ^ b[31]) ? (32'd0 - quot_raw_s) : quot_raw_s;
            rem_s  = a[31] ? (32'd0 - rem_raw_s) : rem_raw_s;
        end else begin
            quot_s = quot_raw_s;
            rem_s  = rem_raw_s;
        end
    end

    // Result select and divide-by-zero detection.
    always_comb begin
        result      = 64'd0;
        div_by_zero = 1'b0;
        case (op)
            MD_MULT, MD_MULTU: begin
                result = product_s;
            end
            MD_DIV, MD_DIVU: begin
                result      = {rem_s, quot_s};
                div_by_zero = (b == 32'd0);
            end
            default: begin
                result      = 64'd0;
                div_by_zero = 1'b0;
            end
        endcase
    end

endmodule : mdu_calc

// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu
// Multi-cycle multiply/divide unit for the execute stage. Owns the
// architectural HI/LO registers. The result is computed combinationally at
// acceptance and held in a staging register; a down-counter models the
// latency, and HI/LO are only written when the counter expires.
//   clk, reset  : clock (rising edge), asynchronous active-low reset
//   start       : qualifies md_op/a/b this cycle (ignored while busy)
//   md_op       : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   a, b        : rs / rt operands (need not be held after acceptance)
//   busy        : high for exactly MULT_CYCLES / DIV_CYCLES after acceptance
//   done        : one-cycle pulse in the first cycle new HI/LO are visible
//   hi, lo      : HI / LO registers
// ---------------------------------------------------------------------------
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic               busy,
    output logic               done,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    mdu_state_t  state_r;
    mdu_state_t  state_nxt_s;
    logic [3:0]  count_r;
    logic [3:0]  count_nxt_s;
    logic [63:0] stage_r;
    logic        skip_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        done_r;
    logic        accept_s;
    logic        commit_s;
    logic        mthi_s;
    logic        mtlo_s;
    logic [63:0] calc_result_s;
    logic        calc_dbz_s;

    mdu_calc u_calc (
        .op          (md_op),
        .a           (a),
        .b           (b),
        .result      (calc_result_s),
        .div_by_zero (calc_dbz_s)
    );

    // Next-state, counter and per-cycle strobes; anything arriving in RUN is dropped.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        accept_s    = 1'b0;
        commit_s    = 1'b0;
        mthi_s      = 1'b0;
        mtlo_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            accept_s    = 1'b1;
                            count_nxt_s = MULT_LOAD;
                            state_nxt_s = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            accept_s    = 1'b1;
                            count_nxt_s = DIV_LOAD;
                            state_nxt_s = ST_RUN;
                        end
                        MD_MTHI: begin
                            mthi_s = 1'b1;
                        end
                        MD_MTLO: begin
                            mtlo_s = 1'b1;
                        end
                        default: begin
                            state_nxt_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (count_r == 4'd1) begin
                    commit_s    = 1'b1;
                    count_nxt_s = 4'd0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    count_nxt_s = count_r - 4'd1;
                end
            end
            default: begin
                count_nxt_s = 4'd0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            count_r <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Staging register, HI/LO and done pulse; a zero-divisor result is never committed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_r <= 64'd0;
            skip_r  <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            done_r  <= 1'b0;
        end else begin
            done_r <= commit_s;
            if (accept_s) begin
                stage_r <= calc_result_s;
                skip_r  <= calc_dbz_s;
            end
            if (commit_s && !skip_r) begin
                hi_r <= stage_r[63:32];
                lo_r <= stage_r[31:0];
            end else if (mthi_s) begin
                hi_r <= a;
            end else if (mtlo_s) begin
                lo_r <= a;
            end
        end
    end

    assign busy = (state_r == ST_RUN);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule : mdu

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu
// Self-checking bench for mdu. Expected {hi,lo} and busy length are pushed
// to a scoreboard queue when an operation is issued and popped when done
// pulses. While busy, HI/LO are checked against the bench's own copy.
// ---------------------------------------------------------------------------
module tb_mdu;
    import mdu_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    typedef struct {
        string       tag;
        logic [63:0] hl;
        int          cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          busy_cnt = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one start request, sampled by the next rising edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Independent reference for the four arithmetic ops.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
        longint          ps;
        longint unsigned pu;
        int              sx, sy, q, r;
        if (op == MD_MULT) begin
            ps = longint'($signed(x)) * longint'($signed(y));
            return 64'(ps);
        end else if (op == MD_MULTU) begin
            pu = longint'({32'd0, x}) * longint'({32'd0, y});
            return 64'(pu);
        end else if (y == 32'd0) begin
            return {hi_m, lo_m};
        end else if (op == MD_DIVU) begin
            return {x % y, x / y};
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            return {32'h0000_0000, 32'h8000_0000};
        end else begin
            sx = $signed(x);
            sy = $signed(y);
            q  = sx / sy;
            r  = sx % sy;
            return {32'(r), 32'(q)};
        end
    endfunction

    task automatic push_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                           input logic [31:0] y, input logic [63:0] hl);
        exp_t e;
        e.tag    = tag;
        e.hl     = hl;
        e.cycles = (op == MD_DIV || op == MD_DIVU) ? ND : NM;
        sb_q.push_back(e);
        issue(op, x, y);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check_eq("drain", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    // Scoreboard monitor: busy length, HI/LO hold during RUN, result on done.
    always @(negedge clk) begin
        exp_t e;
        if (busy) begin
            busy_cnt++;
            check_eq("hold_hilo", {hi, lo}, {hi_m, lo_m});
        end
        if (done) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_done", 64'(done), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq({e.tag, "_hilo"}, {hi, lo}, e.hl);
                check_eq({e.tag, "_busy"}, 64'(busy_cnt), 64'(e.cycles));
                hi_m = e.hl[63:32];
                lo_m = e.hl[31:0];
            end
            busy_cnt = 0;
        end
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] rx, ry;

        // Reset state
        #2 reset = 1'b0;
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Multiply
        push_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        wait_drain(30);
        push_op("multu", MD_MULTU, 32'hFFFF_FFFD, 32'd7, {32'h0000_0006, 32'hFFFF_FFEB});
        wait_drain(30);

        // Divide
        push_op("divu", MD_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
        wait_drain(30);
        push_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        wait_drain(30);
        push_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
        wait_drain(30);

        // Divide by zero leaves preloaded HI/LO
        issue(MD_MTHI, 32'h1111_1111, 32'd0);
        hi_m = 32'h1111_1111;
        issue(MD_MTLO, 32'h2222_2222, 32'd0);
        lo_m = 32'h2222_2222;
        check_eq("preload", {hi, lo}, {32'h1111_1111, 32'h2222_2222});
        push_op("div0", MD_DIV, 32'd5, 32'd0, {32'h1111_1111, 32'h2222_2222});
        wait_drain(30);

        // MTHI in IDLE
        issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
        check_eq("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
        check_eq("mthi_lo", 64'(lo), 64'(lo_m));
        check_eq("mthi_busy", 64'(busy), 64'd0);
        check_eq("mthi_done", 64'(done), 64'd0);
        hi_m = 32'hDEAD_BEEF;

        // Reserved op is a no-op
        issue(3'd6, 32'h1234_5678, 32'd9);
        check_eq("rsv_busy", 64'(busy), 64'd0);
        check_eq("rsv_hilo", {hi, lo}, {hi_m, lo_m});

        // Busy lock-out: MTLO and DIVU during RUN must be ignored
        push_op("lock_mult", MD_MULT, 32'd3, 32'd4, {32'd0, 32'd12});
        issue(MD_MTLO, 32'h0000_0055, 32'd0);
        issue(MD_DIVU, 32'd9, 32'd3);
        wait_drain(30);
        repeat (15) @(negedge clk);
        check_eq("lock_busy", 64'(busy), 64'd0);
        check_eq("lock_hilo", {hi, lo}, {32'd0, 32'd12});

        // Random arithmetic against the reference model
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            rx  = $urandom;
            ry  = (i == 5) ? 32'd0 : $urandom;
            push_op("rand", rop, rx, ry, model(rop, rx, ry));
            wait_drain(30);
        end

        // Reset mid-operation discards the result
        push_op("rst_mid", MD_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_done", 64'(done), 64'd0);
        check_eq("midrst_hilo", {hi, lo}, 64'd0);
        sb_q.delete();
        hi_m     = 32'd0;
        lo_m     = 32'd0;
        busy_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("post_rst_hilo", {hi, lo}, 64'd0);
        check_eq("post_rst_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_mdu

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit for the CPU execute stage.
- Consumes the two register operands (the rs/rt read data) and a decoded operation from the controller.
- Owns the architectural HI/LO registers, which feed the MFHI/MFLO write-back path.
- Presents a busy flag that the controller uses to stall any later MD-class or MFHI/MFLO instruction.

Parameters:
MULT_CYCLES, 5, cycles from an accepted MULT/MULTU to the HI/LO update (legal range 1..15)
DIV_CYCLES, 10, cycles from an accepted DIV/DIVU to the HI/LO update (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  qualifies md_op/a/b this cycle
md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no-op)
a  input  32  operand rs
b  input  32  operand rt
busy  output  1  operation in flight
done  output  1  one-cycle pulse in the first cycle new HI/LO are visible
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, done=0, counter=0, state IDLE. Reset takes effect immediately, including mid-operation, and discards the in-flight result.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, down-counter active.
- Accept rule: on a rising edge with start=1, state IDLE and md_op in 0..3 (call it E0):
  - latch the full result into a 64-bit staging register;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- While in RUN:
  - counter decrements each edge;
  - the edge on which counter==1 writes staging to HI/LO, returns to IDLE and sets done=1 for the next cycle only.
  - busy is therefore high for exactly N cycles after E0, and HI/LO change at edge E0+N.
- HI/LO hold their old values throughout RUN.
- start in RUN is ignored entirely (md_op, a and b are discarded, MTHI/MTLO included). The controller guarantees no issue while busy; the block does not queue.
- MTHI/MTLO:
  - accepted only in IDLE;
  - single-cycle: hi<=a (MTHI) or lo<=a (MTLO) at the accepting edge;
  - busy stays 0 and done stays 0.
- md_op 6/7 with start=1: no state change.
- MULT: signed 32x32 -> 64, hi = upper word, lo = lower word.
- MULTU: unsigned 32x32 -> 64, same HI/LO split.
- DIV:
  - signed; quotient truncates toward zero into lo;
  - remainder carries the sign of the dividend, into hi;
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned; quotient into lo, remainder into hi.
- Divide by zero (b==0, DIV or DIVU):
  - operation is still accepted and busy runs the full DIV_CYCLES;
  - HI/LO are left unchanged at completion;
  - done still pulses.
- a/b need not be held after E0.
- start together with an asynchronous reset assertion: reset wins.

Decomposition:
- Shared package/header holds:
  - MD_MULT/MD_MULTU/MD_DIV/MD_DIVU/MD_MTHI/MD_MTLO op-code constants;
  - the 3-bit md_op width, which the controller also uses.
- One natural sub-module: mdu_calc, purely combinational. Inputs are op, a and b; outputs are the 64-bit {hi,lo} result and a div_by_zero flag.
- mdu keeps the FSM, counter, staging register and HI/LO.

Test Plan:
- MULT a=0xFFFFFFFD(-3), b=7 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses once. MULTU with the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIVU a=100, b=7 -> busy 10 cycles; lo=14, hi=2. DIV a=0xFFFFFFF9(-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero:
  - preload via MTHI 0x11111111 and MTLO 0x22222222;
  - then DIV a=5, b=0 -> busy 10 cycles, done pulses, hi/lo remain 0x11111111/0x22222222.
- MTHI a=0xDEADBEEF in IDLE -> hi=0xDEADBEEF the next cycle, busy never rises, done=0, lo unchanged.
- Busy lock-out:
  - MULT 3*4, then start MTLO a=0x55 and DIVU 9/3 on cycles 2 and 3 of the run;
  - required: both ignored; lo=12, hi=0 at cycle 5; busy drops at cycle 5 and does not re-rise.
- Reset mid-operation:
  - DIVU 100/7, then reset=0 at cycle 4 (between edges);
  - required: busy, done, hi and lo go to 0 immediately;
  - after release, no HI/LO update and no done ever appear.
